// File: rtl/fll_cfg_pkg.sv
// fll_cfg_pkg: shared FSM encoding, target indices and local register map for the FLL config bridge.
package fll_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_ACK_LOW,
        ST_DONE
    } fll_state_e;

    localparam logic [1:0] FLL_SOC     = 2'd0;
    localparam logic [1:0] FLL_PER     = 2'd1;
    localparam logic [1:0] FLL_CLUSTER = 2'd2;
    localparam logic [1:0] FLL_LOCAL   = 2'd3;

    localparam logic [5:0] REG_STATUS  = 6'h30;
    localparam logic [5:0] REG_TIMEOUT = 6'h34;

    localparam int ST_LOCK_SOC     = 0;
    localparam int ST_LOCK_PER     = 1;
    localparam int ST_LOCK_CLUSTER = 2;
    localparam int ST_TIMEOUT      = 3;

    function automatic logic [2:0] fll_onehot(input logic [1:0] tgt);
        return (tgt == FLL_LOCAL) ? 3'b000 : 3'b001 << tgt;
    endfunction

endpackage

// File: rtl/fll_cfg_sync.sv
// fll_cfg_sync: W-bit two-flop synchronizer, or a plain wire when BYPASS is set.
module fll_cfg_sync #(
    parameter int W      = 1,
    parameter bit BYPASS = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (BYPASS) begin : g_bypass
            logic unused_clk;
            assign unused_clk = clk_i ^ rst_i;
            assign q = d;
        end else begin : g_sync
            logic [W-1:0] meta;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    meta <= '0;
                    q    <= '0;
                end else begin
                    meta <= d;
                    q    <= meta;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/apb_fll_cfg_bridge.sv
// apb_fll_cfg_bridge: APB slave driving the SoC/peripheral/cluster FLL req/ack config handshake,
// with synced lock status, a programmable handshake timeout and a sticky timeout flag.
module apb_fll_cfg_bridge
    import fll_cfg_pkg::*;
#(
    parameter int          APB_ADDR_WIDTH = 12,
    parameter bit          ACK_SYNC       = 1'b1,
    parameter logic [15:0] TIMEOUT_RST    = 16'd1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [31:0]               pwdata_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic                      soc_fll_req_o,
    output logic                      soc_fll_wrn_o,
    output logic [1:0]                soc_fll_add_o,
    output logic [31:0]               soc_fll_data_o,
    input  logic                      soc_fll_ack_i,
    input  logic [31:0]               soc_fll_r_data_i,
    input  logic                      soc_fll_lock_i,
    output logic                      per_fll_req_o,
    output logic                      per_fll_wrn_o,
    output logic [1:0]                per_fll_add_o,
    output logic [31:0]               per_fll_data_o,
    input  logic                      per_fll_ack_i,
    input  logic [31:0]               per_fll_r_data_i,
    input  logic                      per_fll_lock_i,
    output logic                      cluster_fll_req_o,
    output logic                      cluster_fll_wrn_o,
    output logic [1:0]                cluster_fll_add_o,
    output logic [31:0]               cluster_fll_data_o,
    input  logic                      cluster_fll_ack_i,
    input  logic [31:0]               cluster_fll_r_data_i,
    input  logic                      cluster_fll_lock_i
);

    fll_state_e  state_q;
    logic [1:0]  tgt_q;
    logic        wrn_q;
    logic [1:0]  add_q;
    logic [31:0] data_q;
    logic [2:0]  req_q;
    logic [2:0]  sel_q;
    logic [15:0] cnt_q;
    logic [15:0] timeout_q;
    logic        sticky_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [2:0]  ack_s;
    logic [2:0]  lock_s;
    logic        ack_cur;
    logic [31:0] r_data_cur;
    logic [5:0]  loc_off;
    logic        is_status;
    logic        is_timeout;
    logic [31:0] status_v;
    logic [31:0] loc_rdata;
    logic [15:0] cnt_nxt;
    logic        unused_addr;

    assign unused_addr = ^{paddr_i[APB_ADDR_WIDTH-1:6], paddr_i[1:0]};

    fll_cfg_sync #(.W(6), .BYPASS(!ACK_SYNC)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     ({cluster_fll_lock_i, per_fll_lock_i, soc_fll_lock_i,
                 cluster_fll_ack_i, per_fll_ack_i, soc_fll_ack_i}),
        .q     ({lock_s, ack_s})
    );

    always_comb begin
        ack_cur    = 1'b0;
        r_data_cur = (tgt_q == FLL_SOC) ? soc_fll_r_data_i :
                     (tgt_q == FLL_PER) ? per_fll_r_data_i : cluster_fll_r_data_i;
        ack_cur    = (tgt_q == FLL_LOCAL) ? 1'b0 : ack_s[tgt_q];
        loc_off    = {paddr_i[5:2], 2'b00};
        is_status  = loc_off == REG_STATUS;
        is_timeout = loc_off == REG_TIMEOUT;
        status_v   = '0;
        status_v[ST_LOCK_SOC]     = lock_s[0];
        status_v[ST_LOCK_PER]     = lock_s[1];
        status_v[ST_LOCK_CLUSTER] = lock_s[2];
        status_v[ST_TIMEOUT]      = sticky_q;
        loc_rdata  = is_status ? status_v : is_timeout ? {16'b0, timeout_q} : 32'b0;
        cnt_nxt    = cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            tgt_q     <= FLL_SOC;
            wrn_q     <= 1'b0;
            add_q     <= 2'b0;
            data_q    <= 32'b0;
            req_q     <= 3'b0;
            sel_q     <= 3'b0;
            cnt_q     <= 16'b0;
            timeout_q <= TIMEOUT_RST;
            sticky_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'b0;
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;
            prdata_o  <= 32'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (psel_i && penable_i) begin
                        tgt_q   <= paddr_i[5:4];
                        wrn_q   <= !pwrite_i;
                        add_q   <= paddr_i[3:2];
                        data_q  <= pwdata_i;
                        cnt_q   <= 16'b0;
                        err_q   <= 1'b0;
                        rdata_q <= 32'b0;
                        if (paddr_i[5:4] == FLL_LOCAL) begin
                            state_q   <= ST_DONE;
                            pready_o  <= 1'b1;
                            pslverr_o <= !(is_status || is_timeout);
                            prdata_o  <= loc_rdata;
                            if (pwrite_i && is_status && pwdata_i[ST_TIMEOUT])
                                sticky_q <= 1'b0;
                            if (pwrite_i && is_timeout)
                                timeout_q <= pwdata_i[15:0];
                        end else begin
                            state_q <= ST_REQ;
                            req_q   <= fll_onehot(paddr_i[5:4]);
                            sel_q   <= fll_onehot(paddr_i[5:4]);
                        end
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_nxt;
                    // An ack arriving on the same cycle as the timeout still wins.
                    if (ack_cur) begin
                        rdata_q <= r_data_cur;
                        req_q   <= 3'b0;
                        state_q <= ST_WAIT_ACK_LOW;
                    end else if (timeout_q != 16'd0 && cnt_nxt == timeout_q) begin
                        err_q    <= 1'b1;
                        sticky_q <= 1'b1;
                        req_q    <= 3'b0;
                        state_q  <= ST_WAIT_ACK_LOW;
                    end
                end
                ST_WAIT_ACK_LOW: begin
                    if (!ack_cur) begin
                        state_q   <= ST_DONE;
                        pready_o  <= 1'b1;
                        pslverr_o <= err_q;
                        prdata_o  <= rdata_q;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    pready_o  <= 1'b0;
                    pslverr_o <= 1'b0;
                    prdata_o  <= 32'b0;
                    sel_q     <= 3'b0;
                end
            endcase
        end
    end

    // Only the FLL owning the current transaction sees non-zero command fields.
    assign soc_fll_req_o      = req_q[FLL_SOC];
    assign soc_fll_wrn_o      = sel_q[FLL_SOC] & wrn_q;
    assign soc_fll_add_o      = sel_q[FLL_SOC] ? add_q : 2'b0;
    assign soc_fll_data_o     = sel_q[FLL_SOC] ? data_q : 32'b0;
    assign per_fll_req_o      = req_q[FLL_PER];
    assign per_fll_wrn_o      = sel_q[FLL_PER] & wrn_q;
    assign per_fll_add_o      = sel_q[FLL_PER] ? add_q : 2'b0;
    assign per_fll_data_o     = sel_q[FLL_PER] ? data_q : 32'b0;
    assign cluster_fll_req_o  = req_q[FLL_CLUSTER];
    assign cluster_fll_wrn_o  = sel_q[FLL_CLUSTER] & wrn_q;
    assign cluster_fll_add_o  = sel_q[FLL_CLUSTER] ? add_q : 2'b0;
    assign cluster_fll_data_o = sel_q[FLL_CLUSTER] ? data_q : 32'b0;

endmodule

// File: tb/tb_apb_fll_cfg_bridge.sv
// tb_apb_fll_cfg_bridge: table vectors, random traffic against a register-map model,
// and directed timeout / lock / back-to-back / reset sequences.
module tb_apb_fll_cfg_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [11:0] paddr_i = '0;
    logic        psel_i = 1'b0;
    logic        penable_i = 1'b0;
    logic        pwrite_i = 1'b0;
    logic [31:0] pwdata_i = '0;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic        soc_fll_req_o, per_fll_req_o, cluster_fll_req_o;
    logic        soc_fll_wrn_o, per_fll_wrn_o, cluster_fll_wrn_o;
    logic [1:0]  soc_fll_add_o, per_fll_add_o, cluster_fll_add_o;
    logic [31:0] soc_fll_data_o, per_fll_data_o, cluster_fll_data_o;
    logic [31:0] soc_r, per_r, cluster_r;
    logic [2:0]  ack_v = '0;
    logic [2:0]  lock_v = '0;
    logic [2:0]  alive = 3'b111;
    logic [31:0] dev_mem [3][4];

    logic [2:0]  req_v, wrn_v;
    logic [1:0]  add_v [3];
    logic [31:0] dat_v [3];

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [3][4];
    logic [15:0] ref_timeout;
    logic        ref_sticky;

    always #5 clk_i = ~clk_i;

    apb_fll_cfg_bridge dut (
        .clk_i(clk_i), .rst_i(rst_i), .paddr_i(paddr_i), .psel_i(psel_i),
        .penable_i(penable_i), .pwrite_i(pwrite_i), .pwdata_i(pwdata_i),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .soc_fll_req_o(soc_fll_req_o), .soc_fll_wrn_o(soc_fll_wrn_o),
        .soc_fll_add_o(soc_fll_add_o), .soc_fll_data_o(soc_fll_data_o),
        .soc_fll_ack_i(ack_v[0]), .soc_fll_r_data_i(soc_r), .soc_fll_lock_i(lock_v[0]),
        .per_fll_req_o(per_fll_req_o), .per_fll_wrn_o(per_fll_wrn_o),
        .per_fll_add_o(per_fll_add_o), .per_fll_data_o(per_fll_data_o),
        .per_fll_ack_i(ack_v[1]), .per_fll_r_data_i(per_r), .per_fll_lock_i(lock_v[1]),
        .cluster_fll_req_o(cluster_fll_req_o), .cluster_fll_wrn_o(cluster_fll_wrn_o),
        .cluster_fll_add_o(cluster_fll_add_o), .cluster_fll_data_o(cluster_fll_data_o),
        .cluster_fll_ack_i(ack_v[2]), .cluster_fll_r_data_i(cluster_r),
        .cluster_fll_lock_i(lock_v[2])
    );

    assign req_v = {cluster_fll_req_o, per_fll_req_o, soc_fll_req_o};
    assign wrn_v = {cluster_fll_wrn_o, per_fll_wrn_o, soc_fll_wrn_o};
    assign add_v[0] = soc_fll_add_o;
    assign add_v[1] = per_fll_add_o;
    assign add_v[2] = cluster_fll_add_o;
    assign dat_v[0] = soc_fll_data_o;
    assign dat_v[1] = per_fll_data_o;
    assign dat_v[2] = cluster_fll_data_o;
    assign soc_r     = dev_mem[0][soc_fll_add_o];
    assign per_r     = dev_mem[1][per_fll_add_o];
    assign cluster_r = dev_mem[2][cluster_fll_add_o];

    // FLL device model: ack follows req one cycle later, write lands with the ack.
    always @(posedge clk_i) begin
        for (int i = 0; i < 3; i++) begin
            if (req_v[i] && alive[i] && !ack_v[i] && !wrn_v[i])
                dev_mem[i][add_v[i]] <= dat_v[i];
            ack_v[i] <= req_v[i] & alive[i];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Register-map reference: returns expected read data, error and wait states.
    task automatic ref_access(input logic [11:0] a, input logic w, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er, output int lat);
        int t = int'(a[5:4]);
        int r = int'(a[3:2]);
        rd = 32'h0;
        er = 1'b0;
        if (t < 3) begin
            lat = 9;
            if (w) ref_mem[t][r] = wd;
            else rd = ref_mem[t][r];
        end else begin
            lat = 1;
            if (r == 0) begin
                rd = {28'h0, ref_sticky, lock_v};
                if (w && wd[3]) ref_sticky = 1'b0;
            end else if (r == 1) begin
                rd = {16'h0, ref_timeout};
                if (w) ref_timeout = wd[15:0];
            end else begin
                er = 1'b1;
            end
        end
    endtask

    task automatic apb(input logic [11:0] a, input logic w, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat,
                       output int rq_first, output int rq_cnt, output int bad);
        int t = int'(a[5:4]);
        rd = '0; er = 1'b0; lat = -1; rq_first = -1; rq_cnt = 0; bad = 0;
        paddr_i = a; pwrite_i = w; pwdata_i = wd; psel_i = 1'b1; penable_i = 1'b0;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk_i); #1;
            for (int i = 0; i < 3; i++) begin
                if (i != t) begin
                    if (req_v[i] || wrn_v[i] || add_v[i] != 2'b0 || dat_v[i] != 32'h0) bad++;
                end else if (req_v[i]) begin
                    if (rq_first < 0) rq_first = n;
                    rq_cnt++;
                    if (wrn_v[i] != !w || add_v[i] != a[3:2] || dat_v[i] != wd) bad++;
                    if ((ack_v & ~(3'b001 << i)) != 3'b000) bad++;
                end
            end
            if (pready_o) begin
                lat = n; rd = prdata_o; er = pslverr_o;
                break;
            end
        end
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    task automatic run(input string nm, input logic [11:0] a, input logic w, input logic [31:0] wd);
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, elat, f, c, bad;
        ref_access(a, w, wd, erd, eer, elat);
        apb(a, w, wd, rd, er, lat, f, c, bad);
        check({nm, "_lat"}, lat, elat);
        check({nm, "_err"}, {31'b0, er}, {31'b0, eer});
        check({nm, "_side"}, bad, 0);
        if (!w) check({nm, "_rdata"}, rd, erd);
    endtask

    typedef struct packed {
        logic [11:0] a;
        logic        w;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
        logic [7:0]  lat;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat, mlat, f, c, bad;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++) begin
                dev_mem[i][j] = 32'hF000_0000 | (i << 8) | j;
                ref_mem[i][j] = 32'hF000_0000 | (i << 8) | j;
            end
        dev_mem[2][2] = 32'hCAFE_0001;
        ref_mem[2][2] = 32'hCAFE_0001;
        ref_timeout = 16'd1024;
        ref_sticky  = 1'b0;

        tbl[0]  = '{12'h004, 1'b1, 32'h0000_1234, 32'h0, 1'b0, 8'd9};
        tbl[1]  = '{12'h004, 1'b0, 32'h0,         32'h0000_1234, 1'b0, 8'd9};
        tbl[2]  = '{12'h028, 1'b0, 32'h0,         32'hCAFE_0001, 1'b0, 8'd9};
        tbl[3]  = '{12'h018, 1'b1, 32'hA5A5_0F0F, 32'h0, 1'b0, 8'd9};
        tbl[4]  = '{12'h018, 1'b0, 32'h0,         32'hA5A5_0F0F, 1'b0, 8'd9};
        tbl[5]  = '{12'h038, 1'b0, 32'h0,         32'h0, 1'b1, 8'd1};
        tbl[6]  = '{12'h03C, 1'b0, 32'h0,         32'h0, 1'b1, 8'd1};
        tbl[7]  = '{12'h034, 1'b1, 32'hFFFF_0200, 32'h0, 1'b0, 8'd1};
        tbl[8]  = '{12'h034, 1'b0, 32'h0,         32'h0000_0200, 1'b0, 8'd1};
        tbl[9]  = '{12'h030, 1'b0, 32'h0,         32'h0, 1'b0, 8'd1};
        tbl[10] = '{12'h034, 1'b1, 32'h0000_0400, 32'h0, 1'b0, 8'd1};
        tbl[11] = '{12'h02C, 1'b0, 32'h0,         32'hF000_0203, 1'b0, 8'd9};

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_pready", {31'b0, pready_o}, 0);
        check("rst_pslverr", {31'b0, pslverr_o}, 0);
        check("rst_prdata", prdata_o, 0);
        check("rst_req", {29'b0, req_v}, 0);
        check("rst_cmd", {29'b0, wrn_v} | {30'b0, add_v[0] | add_v[1] | add_v[2]}
              | dat_v[0] | dat_v[1] | dat_v[2], 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int k = 0; k < 12; k++) begin
            ref_access(tbl[k].a, tbl[k].w, tbl[k].wd, mrd, mer, mlat);
            apb(tbl[k].a, tbl[k].w, tbl[k].wd, rd, er, lat, f, c, bad);
            check($sformatf("tbl%0d_lat", k), lat, {24'b0, tbl[k].lat});
            check($sformatf("tbl%0d_err", k), {31'b0, er}, {31'b0, tbl[k].er});
            check($sformatf("tbl%0d_side", k), bad, 0);
            if (!tbl[k].w) check($sformatf("tbl%0d_rdata", k), rd, tbl[k].rd);
            if (tbl[k].a[5:4] != 2'd3) check($sformatf("tbl%0d_req_rise", k), f, 1);
        end

        for (int k = 0; k < 60; k++) begin
            logic [11:0] a;
            logic [31:0] wd;
            logic w;
            a = {6'($urandom), 2'($urandom), 2'($urandom), 2'($urandom)};
            w = 1'($urandom);
            wd = $urandom;
            if (a[5:2] == 4'hD) wd[15:0] = $urandom_range(1) ? 16'd0 : 16'($urandom_range(1000, 16));
            run($sformatf("rnd%0d", k), a, w, wd);
        end

        // Timeout: peripheral FLL never answers.
        run("tmo_set", 12'h034, 1'b1, 32'd8);
        alive[1] = 1'b0;
        apb(12'h010, 1'b1, 32'h1357_9BDF, rd, er, lat, f, c, bad);
        ref_sticky = 1'b1;
        check("tmo_err", {31'b0, er}, 1);
        check("tmo_req_cycles", c, 8);
        check("tmo_side", bad, 0);
        alive[1] = 1'b1;
        run("tmo_status", 12'h030, 1'b0, 0);
        run("tmo_clear", 12'h030, 1'b1, 32'h8);
        run("tmo_status2", 12'h030, 1'b0, 0);
        run("tmo_nowrite", 12'h010, 1'b0, 0);

        lock_v = 3'b101;
        repeat (2) @(posedge clk_i);
        #1;
        run("lock_101", 12'h030, 1'b0, 0);
        lock_v = 3'b010;
        repeat (2) @(posedge clk_i);
        #1;
        run("lock_010", 12'h030, 1'b0, 0);
        lock_v = 3'b101;
        repeat (2) @(posedge clk_i);
        #1;

        run("b2b_soc", 12'h00C, 1'b1, 32'h1111_2222);
        run("b2b_per", 12'h01C, 1'b1, 32'h3333_4444);
        run("b2b_clu", 12'h024, 1'b1, 32'h5555_6666);
        run("b2b_rd_soc", 12'h00C, 1'b0, 0);
        run("b2b_rd_per", 12'h01C, 1'b0, 0);

        // Reset while the SoC FLL request is pending.
        alive[0] = 1'b0;
        paddr_i = 12'h000; pwrite_i = 1'b1; pwdata_i = 32'hDEAD_BEEF;
        psel_i = 1'b1; penable_i = 1'b0;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        @(posedge clk_i); #1;
        check("mid_req_up", {31'b0, soc_fll_req_o}, 1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("mid_req_drop", {29'b0, req_v}, 0);
        check("mid_pready", {31'b0, pready_o}, 0);
        psel_i = 1'b0; penable_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        alive[0] = 1'b1;
        ref_timeout = 16'd1024;
        ref_sticky = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        run("post_rst_timeout", 12'h034, 1'b0, 0);
        run("post_rst_status", 12'h030, 1'b0, 0);
        run("post_rst_soc", 12'h000, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
